// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave (the subtractor) drives the result side.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
// Operands are captured on an accepted start; done pulses for one cycle when
// diff/bout carry the new result. All outputs are registered.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sa_next;
    logic [WIDTH-1:0] sb, sb_next;
    logic             borrow, borrow_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] diff_q, diff_next;
    logic             bout_q, bout_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;

    logic             x, y, d, borrow_bit, last_bit;
    logic [WIDTH-1:0] sa_shift;

    // Full-subtractor cell on the current LSBs and registered borrow.
    assign x          = sa[0];
    assign y          = sb[0];
    assign d          = x ^ y ^ borrow;
    assign borrow_bit = (~x & y) | (~(x ^ y) & borrow);
    assign last_bit   = (count == CW'(WIDTH - 1));

    // The minuend register doubles as the result shift register: each
    // difference bit enters at the MSB as the consumed minuend bit leaves at
    // the LSB, so after WIDTH shifts sa holds the complete result.
    generate
        if (WIDTH == 1) begin : g_single
            assign sa_shift = d;
        end else begin : g_multi
            assign sa_shift = {d, sa[WIDTH-1:1]};
        end
    endgenerate

    // State and datapath registers; reset clears everything, aborting any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            sa     <= sa_next;
            sb     <= sb_next;
            borrow <= borrow_next;
            count  <= count_next;
            diff_q <= diff_next;
            bout_q <= bout_next;
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    // Next-state, datapath and output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_next  = state;
        sa_next     = sa;
        sb_next     = sb;
        borrow_next = borrow;
        count_next  = count;
        diff_next   = diff_q;
        bout_next   = bout_q;
        busy_next   = busy_q;
        done_next   = 1'b0;

        unique case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    sa_next     = bus.a;
                    sb_next     = bus.b;
                    borrow_next = bus.bin;
                    count_next  = '0;
                    busy_next   = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                sa_next     = sa_shift;
                sb_next     = sb >> 1;
                borrow_next = borrow_bit;
                count_next  = count + CW'(1);
                if (last_bit) begin
                    diff_next  = sa_shift;
                    bout_next  = borrow_bit;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH = 8, 4 and 1.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;

    logic [7:0] last_diff8 = '0;
    logic       last_bout8 = 1'b0;
    int         done_edge  = 0;
    int         first_done = 0;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle cycles: nothing running anywhere, WIDTH=8 result held.
    task automatic idle(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk({tag, "_busy8"}, 32'(if8.busy), 32'd0);
            chk({tag, "_done8"}, 32'(if8.done), 32'd0);
            chk({tag, "_diff8"}, 32'(if8.diff), 32'(last_diff8));
            chk({tag, "_bout8"}, 32'(if8.bout), 32'(last_bout8));
            chk({tag, "_busy4"}, 32'(if4.busy), 32'd0);
            chk({tag, "_done4"}, 32'(if4.done), 32'd0);
            chk({tag, "_busy1"}, 32'(if1.busy), 32'd0);
            chk({tag, "_done1"}, 32'(if1.done), 32'd0);
        end
    endtask

    // One WIDTH=8 operation, called at a negedge; returns at the negedge of
    // the done cycle. poke>0 raises start with a=100,b=1 at that cycle;
    // scramble changes a/b/bin every cycle after acceptance.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed, input logic eb,
                       input int poke, input bit scramble, input string tag);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bi;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if8.start = 1'b0;
            chk({tag, "_busy"}, 32'(if8.busy), 32'(n <= 8));
            chk({tag, "_done"}, 32'(if8.done), 32'(n == 9));
            if (n == 1) begin
                chk({tag, "_hold_diff"}, 32'(if8.diff), 32'(last_diff8));
                chk({tag, "_hold_bout"}, 32'(if8.bout), 32'(last_bout8));
            end
            if (n == 9) begin
                chk({tag, "_diff"}, 32'(if8.diff), 32'(ed));
                chk({tag, "_bout"}, 32'(if8.bout), 32'(eb));
                done_edge = edges;
            end
            if (poke == n) begin
                if8.start = 1'b1;
                if8.a     = 8'd100;
                if8.b     = 8'd1;
                if8.bin   = 1'b0;
            end else if (scramble) begin
                if8.a   = 8'($urandom);
                if8.b   = 8'($urandom);
                if8.bin = 1'($urandom_range(0, 1));
            end
        end
        last_diff8 = ed;
        last_bout8 = eb;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rbi;
        logic [7:0] e8;
        logic [3:0] e4;
        logic       e1;
        logic       eb8, eb4, eb1;

        rst = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_diff", 32'(if8.diff), 32'd0);
        chk("rst_bout", 32'(if8.bout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(5, "post_rst");

        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, 1'b0, "basic");
        idle(2, "i1");
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, 1'b0, "under");
        idle(1, "i2");
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0, 1'b0, "bin");
        idle(1, "i3");
        op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 1'b0, "ffff");
        idle(1, "i4");
        op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 3, 1'b0, "poke");
        idle(3, "after_poke");
        op8(8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 0, 1'b1, "scramble");
        if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        idle(1, "i5");

        // Back-to-back: second start issued during the first done cycle.
        op8(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 0, 1'b0, "b2b_first");
        first_done = done_edge;
        op8(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 0, 1'b0, "b2b_second");
        chk("b2b_gap", 32'(done_edge - first_done), 32'd9);
        idle(1, "i6");

        // Abort mid-run with a nonzero previous result on display.
        op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0, 1'b0, "pre_abort");
        idle(1, "i7");
        if8.start = 1'b1; if8.a = 8'h09; if8.b = 8'h04; if8.bin = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if8.start = 1'b0;
            chk("abort_busy", 32'(if8.busy), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_busy0", 32'(if8.busy), 32'd0);
        chk("abort_done0", 32'(if8.done), 32'd0);
        chk("abort_diff0", 32'(if8.diff), 32'd0);
        chk("abort_bout0", 32'(if8.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_diff8 = '0;
        last_bout8 = 1'b0;
        idle(12, "post_abort");
        op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 0, 1'b0, "after_abort");

        // Randomized operations on all three widths against arithmetic.
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom_range(0, 1));
            e8  = ra - rb - {7'b0, rbi};
            e4  = ra[3:0] - rb[3:0] - {3'b0, rbi};
            e1  = ra[0] ^ rb[0] ^ rbi;
            eb8 = (int'(ra) < int'(rb) + int'(rbi));
            eb4 = (int'(ra[3:0]) < int'(rb[3:0]) + int'(rbi));
            eb1 = (int'(ra[0]) < int'(rb[0]) + int'(rbi));
            if8.start = 1'b1; if8.a = ra;      if8.b = rb;      if8.bin = rbi;
            if4.start = 1'b1; if4.a = ra[3:0]; if4.b = rb[3:0]; if4.bin = rbi;
            if1.start = 1'b1; if1.a = ra[0];   if1.b = rb[0];   if1.bin = rbi;
            for (int n = 1; n <= 9; n++) begin
                @(negedge clk);
                if8.start = 1'b0;
                if4.start = 1'b0;
                if1.start = 1'b0;
                chk("rnd_busy8", 32'(if8.busy), 32'(n <= 8));
                chk("rnd_busy4", 32'(if4.busy), 32'(n <= 4));
                chk("rnd_busy1", 32'(if1.busy), 32'(n <= 1));
                chk("rnd_done8", 32'(if8.done), 32'(n == 9));
                chk("rnd_done4", 32'(if4.done), 32'(n == 5));
                chk("rnd_done1", 32'(if1.done), 32'(n == 2));
                if (n == 9) begin
                    chk("rnd_diff8", 32'(if8.diff), 32'(e8));
                    chk("rnd_bout8", 32'(if8.bout), 32'(eb8));
                end
                if (n == 5) begin
                    chk("rnd_diff4", 32'(if4.diff), 32'(e4));
                    chk("rnd_bout4", 32'(if4.bout), 32'(eb4));
                end
                if (n == 2) begin
                    chk("rnd_diff1", 32'(if1.diff), 32'(e1));
                    chk("rnd_bout1", 32'(if1.bout), 32'(eb1));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
